// File: rtl/arg_arb_pkg.sv
// Shared definitions for the argument-port arbiter: FSM encoding and default sizes.
package arg_arb_pkg;

    localparam int DEF_NUM_REQ    = 2;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arg_port_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 with wrap-around.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic w_found;
    int   w_cand;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(i_last) + k) % NUM_REQ;
            if (!w_found && i_req[IDX_W'(w_cand)]) begin
                w_found                = 1'b1;
                o_gnt[IDX_W'(w_cand)]  = 1'b1;
                o_idx                  = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/arg_port_arbiter.sv
// Round-robin arbiter sharing one single-port argument memory between NUM_REQ requesters.
module arg_port_arbiter
    import arg_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          ce0,
    output logic                          we0,
    output logic [DATA_WIDTH-1:0]         mem_din0,
    input  logic [DATA_WIDTH-1:0]         mem_dout0,
    input  logic                          done,
    output logic                          idle,
    output logic [15:0]                   access_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              r_state;
    logic [IDX_W-1:0]        r_last;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [15:0]             r_access_count;

    logic [NUM_REQ-1:0]      w_gnt;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_any;
    logic                    w_can_grant;
    logic                    w_access;
    logic                    w_resp;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_gnt_idx),
        .o_any  (w_any)
    );

    assign w_access = (r_state == ST_ACCESS);
    assign w_resp   = (r_state == ST_RESP);

    // rst gates the grant so nothing is accepted while reset is held
    assign w_can_grant = !rst && !done && w_any &&
                         ((r_state == ST_IDLE) || w_resp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_last         <= IDX_W'(NUM_REQ - 1);
            r_idx          <= '0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_access_count <= '0;
        end else begin
            if (w_resp)
                r_access_count <= r_access_count + 16'd1;
            if (w_can_grant) begin
                r_state <= ST_ACCESS;
                r_last  <= w_gnt_idx;
                r_idx   <= w_gnt_idx;
                r_we    <= req_we[w_gnt_idx];
                r_wdata <= req_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                case (r_state)
                    ST_ACCESS: r_state <= ST_RESP;
                    default:   r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Memory-side and response outputs decode straight from the registered state
    assign req_ready    = w_can_grant ? w_gnt : '0;
    assign ce0          = w_access;
    assign we0          = w_access & r_we;
    assign mem_din0     = w_access ? r_wdata : '0;
    assign rsp_valid    = w_resp ? (NUM_REQ'(1) << r_idx) : '0;
    assign rsp_data     = w_resp ? mem_dout0 : '0;
    assign idle         = (r_state == ST_IDLE);
    assign access_count = r_access_count;

endmodule

// File: doc/arg_port_arbiter.md
ARG_PORT_ARBITER -- requirements
Module: arg_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, argument word width.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have req_valid  input  NUM_REQ  per-requester access request, held until accepted.
REQ-006 SHALL have req_we  input  NUM_REQ  per-requester write flag (1 = write, 0 = read).
REQ-007 SHALL have req_wdata  input  NUM_REQ*DATA_WIDTH  per-requester write data, slice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have req_ready  output  NUM_REQ  one-hot acceptance pulse.
REQ-009 SHALL have rsp_valid  output  NUM_REQ  one-hot completion pulse, reads and writes.
REQ-010 SHALL have rsp_data  output  DATA_WIDTH  read data, meaningful only with a read completion.
REQ-011 SHALL have ce0, we0  output  1 each  argument memory chip enable and write enable.
REQ-012 SHALL have mem_din0  output  DATA_WIDTH  write data to memory.
REQ-013 SHALL have mem_dout0  input  DATA_WIDTH  memory read data, registered by memory, valid the cycle after ce0.
REQ-014 SHALL have done  input  1  transaction boundary; memory contents owned by file I/O while high.
REQ-015 SHALL have idle  output  1  high when state is IDLE and no response pending.
REQ-016 SHALL have access_count  output  16  number of completed accesses.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 In IDLE or RESP with done low and any req_valid high, SHALL pick one requester round-robin, assert its req_ready combinationally that cycle, latch its req_we/req_wdata and index, and go to ACCESS.
REQ-019 Round-robin SHALL search from (last_grant+1) mod NUM_REQ upward with wrap-around; last_grant updates on every grant.
REQ-020 In ACCESS SHALL drive ce0=1, we0=latched we, mem_din0=latched wdata for exactly one cycle, then go to RESP.
REQ-021 In RESP SHALL assert rsp_valid[granted] for exactly one cycle, drive rsp_data=mem_dout0, increment access_count (16-bit, wraps 0xFFFF->0).
REQ-022 From RESP SHALL go to ACCESS if a new grant is made per REQ-018, else IDLE; peak throughput one access per 2 cycles.
REQ-023 Outside ACCESS, ce0, we0 SHALL be 0 and mem_din0 SHALL be 0.
REQ-024 While done is high no new grant SHALL be made; an access already in ACCESS or RESP SHALL complete normally.
REQ-025 A requester dropping req_valid before req_ready SHALL not be granted; simultaneous requests SHALL yield exactly one req_ready bit.
REQ-026 req_ready and rsp_valid SHALL never have more than one bit set.

Reset
REQ-027 On rst high, asynchronously: state IDLE, last_grant NUM_REQ-1 (requester 0 first), latched we/wdata/index 0, access_count 0.
REQ-028 During and immediately after reset: req_ready, rsp_valid, rsp_data, ce0, we0, mem_din0 all 0, idle 1.
REQ-029 Reset mid-ACCESS or mid-RESP SHALL abandon the access with no rsp_valid issued.

Structure
REQ-030 Package arg_arb_pkg SHALL hold FSM state encoding (IDLE=0, ACCESS=1, RESP=2) and default NUM_REQ/DATA_WIDTH constants.
REQ-031 SHALL instantiate one combinational sub-module rr_pick (req vector, last_grant -> one-hot grant, grant index, any flag).
REQ-032 Total RTL 120-400 lines; no delays in synthesizable code.

Verification
REQ-033 Single write: req_valid=01, req_we=1, wdata0=0xDEADBEEF, done=0 -> req_ready=01 cycle 0, ce0=we0=1 with mem_din0=0xDEADBEEF cycle 1, rsp_valid=01 cycle 2, access_count=1.
REQ-034 Read-back: after REQ-033, requester 1 read -> ce0=1, we0=0 at cycle 1, rsp_valid=10 with rsp_data=0xDEADBEEF at cycle 2.
REQ-035 Contention: req_valid=11 held, six accesses -> grants alternate 0,1,0,1,0,1, req_ready spaced 2 cycles, access_count=6.
REQ-036 done gating: raise done during ACCESS -> that access completes with rsp_valid; no req_ready while done=1; first grant on first cycle after done falls.
REQ-037 Reset mid-operation: assert rst in ACCESS -> ce0, rsp_valid, access_count 0 immediately; after release requester 0 granted first with req_valid=11.
REQ-038 Wrap: preload access_count 0xFFFF via 65535 accesses (or force) -> next completion gives 0x0000.
